// File: rtl/soc_addr_decoder.sv
// Address decode stage in front of the SoC peripheral crossbar: registers mapped requests
// with a one-hot target select and answers unmapped requests locally with DECERR beats.
module soc_addr_decoder #(
    parameter int NbPeriph = 11,
    parameter int IdWidth  = 5,
    parameter int CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [63:0]         req_addr_i,
    input  logic                req_write_i,
    input  logic [IdWidth-1:0]  req_id_i,
    input  logic [7:0]          req_len_i,
    output logic                mst_valid_o,
    input  logic                mst_ready_i,
    output logic [63:0]         mst_addr_o,
    output logic                mst_write_o,
    output logic [IdWidth-1:0]  mst_id_o,
    output logic [7:0]          mst_len_o,
    output logic [NbPeriph-1:0] mst_sel_o,
    output logic [3:0]          mst_idx_o,
    output logic                err_valid_o,
    input  logic                err_ready_i,
    output logic [IdWidth-1:0]  err_id_o,
    output logic [1:0]          err_resp_o,
    output logic                err_last_o,
    output logic                err_write_o,
    output logic [CntWidth-1:0] decerr_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        ERR  = 2'd2
    } state_e;

    state_e               state_r;
    logic [7:0]           err_len_r;
    logic [7:0]           beat_cnt_r;
    logic                 hit_s;
    logic [3:0]           idx_s;
    logic [NbPeriph-1:0]  sel_s;
    logic                 accept_s;

    function automatic logic [63:0] region_base(input logic [3:0] idx);
        case (idx)
            4'd0:    region_base = 64'h0000_0000_5000_0000;
            4'd1:    region_base = 64'h0000_0000_8000_0000;
            4'd2:    region_base = 64'h0000_0000_4000_0000;
            4'd3:    region_base = 64'h0000_0000_3000_0000;
            4'd4:    region_base = 64'h0000_0000_2000_0000;
            4'd5:    region_base = 64'h0000_0000_1800_0000;
            4'd6:    region_base = 64'h0000_0000_1000_0000;
            4'd7:    region_base = 64'h0000_0000_0C00_0000;
            4'd8:    region_base = 64'h0000_0000_0200_0000;
            4'd9:    region_base = 64'h0000_0000_0001_0000;
            4'd10:   region_base = 64'h0000_0000_0000_0000;
            default: region_base = 64'h0000_0000_0000_0000;
        endcase
    endfunction

    // A zero length makes an index unmatchable.
    function automatic logic [63:0] region_len(input logic [3:0] idx);
        case (idx)
            4'd0:    region_len = 64'h0000_0000_03FF_FFFF;
            4'd1:    region_len = 64'h0000_0000_4000_0000;
            4'd2:    region_len = 64'h0000_0000_0000_1000;
            4'd3:    region_len = 64'h0000_0000_0001_0000;
            4'd4:    region_len = 64'h0000_0000_0080_0000;
            4'd5:    region_len = 64'h0000_0000_0000_1000;
            4'd6:    region_len = 64'h0000_0000_0000_1000;
            4'd7:    region_len = 64'h0000_0000_03FF_FFFF;
            4'd8:    region_len = 64'h0000_0000_000C_0000;
            4'd9:    region_len = 64'h0000_0000_0001_0000;
            4'd10:   region_len = 64'h0000_0000_0000_1000;
            default: region_len = 64'h0000_0000_0000_0000;
        endcase
    endfunction

    // Address match; scanning downward lets the lowest matching index win.
    always_comb begin
        hit_s = 1'b0;
        idx_s = 4'd0;
        for (int i = NbPeriph - 1; i >= 0; i--) begin
            // Unsigned wrap of (addr - base) folds both region bounds into one compare.
            if ((req_addr_i - region_base(4'(i))) < region_len(4'(i))) begin
                hit_s = 1'b1;
                idx_s = 4'(i);
            end else begin
                hit_s = hit_s;
                idx_s = idx_s;
            end
        end
    end

    assign sel_s    = {{(NbPeriph-1){1'b0}}, 1'b1} << idx_s;
    assign accept_s = req_valid_i & req_ready_o;

    // Request ready per state; FWD passes mst_ready_i through for full throughput.
    always_comb begin
        case (state_r)
            IDLE:    req_ready_o = 1'b1;
            FWD:     req_ready_o = mst_ready_i;
            default: req_ready_o = 1'b0;
        endcase
    end

    // Control FSM with all request/response outputs registered.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r      <= IDLE;
            mst_valid_o  <= 1'b0;
            mst_addr_o   <= 64'd0;
            mst_write_o  <= 1'b0;
            mst_id_o     <= {IdWidth{1'b0}};
            mst_len_o    <= 8'd0;
            mst_sel_o    <= {NbPeriph{1'b0}};
            mst_idx_o    <= 4'd0;
            err_valid_o  <= 1'b0;
            err_id_o     <= {IdWidth{1'b0}};
            err_resp_o   <= 2'b00;
            err_last_o   <= 1'b0;
            err_write_o  <= 1'b0;
            err_len_r    <= 8'd0;
            beat_cnt_r   <= 8'd0;
            decerr_cnt_o <= {CntWidth{1'b0}};
        end else if (accept_s && hit_s) begin
            state_r     <= FWD;
            mst_valid_o <= 1'b1;
            mst_addr_o  <= req_addr_i;
            mst_write_o <= req_write_i;
            mst_id_o    <= req_id_i;
            mst_len_o   <= req_len_i;
            mst_sel_o   <= sel_s;
            mst_idx_o   <= idx_s;
        end else if (accept_s) begin
            state_r     <= ERR;
            mst_valid_o <= 1'b0;
            mst_addr_o  <= 64'd0;
            mst_write_o <= 1'b0;
            mst_id_o    <= {IdWidth{1'b0}};
            mst_len_o   <= 8'd0;
            mst_sel_o   <= {NbPeriph{1'b0}};
            mst_idx_o   <= 4'd0;
            err_valid_o <= 1'b1;
            err_id_o    <= req_id_i;
            err_resp_o  <= 2'b11;
            err_write_o <= req_write_i;
            err_last_o  <= req_write_i | (req_len_i == 8'd0);
            err_len_r   <= req_len_i;
            beat_cnt_r  <= 8'd0;
            if (decerr_cnt_o != {CntWidth{1'b1}}) begin
                decerr_cnt_o <= decerr_cnt_o + CntWidth'(1);
            end
        end else if (state_r == FWD && mst_ready_i) begin
            state_r     <= IDLE;
            mst_valid_o <= 1'b0;
            mst_addr_o  <= 64'd0;
            mst_write_o <= 1'b0;
            mst_id_o    <= {IdWidth{1'b0}};
            mst_len_o   <= 8'd0;
            mst_sel_o   <= {NbPeriph{1'b0}};
            mst_idx_o   <= 4'd0;
        end else if (state_r == ERR && err_ready_i) begin
            if (err_last_o) begin
                state_r     <= IDLE;
                err_valid_o <= 1'b0;
                err_id_o    <= {IdWidth{1'b0}};
                err_resp_o  <= 2'b00;
                err_last_o  <= 1'b0;
                err_write_o <= 1'b0;
                err_len_r   <= 8'd0;
                beat_cnt_r  <= 8'd0;
            end else begin
                beat_cnt_r <= beat_cnt_r + 8'd1;
                err_last_o <= ((beat_cnt_r + 8'd1) == err_len_r);
            end
        end
    end

endmodule

// File: tb/tb_soc_addr_decoder.sv
// Randomized self-checking bench for soc_addr_decoder against a table-driven address-map model.
module tb_soc_addr_decoder;
    localparam int NbPeriph = 11;
    localparam int IdWidth  = 5;
    localparam int CntWidth = 16;

    localparam logic [63:0] MAP_BASE [NbPeriph] = '{
        64'h5000_0000, 64'h8000_0000, 64'h4000_0000, 64'h3000_0000, 64'h2000_0000, 64'h1800_0000,
        64'h1000_0000, 64'h0C00_0000, 64'h0200_0000, 64'h0001_0000, 64'h0000_0000};
    localparam logic [63:0] MAP_LEN [NbPeriph] = '{
        64'h03FF_FFFF, 64'h4000_0000, 64'h0000_1000, 64'h0001_0000, 64'h0080_0000, 64'h0000_1000,
        64'h0000_1000, 64'h03FF_FFFF, 64'h000C_0000, 64'h0001_0000, 64'h0000_1000};

    logic                clk = 1'b0;
    logic                rst_ni = 1'b0;
    logic                req_valid_i = 1'b0;
    logic                req_ready_o;
    logic [63:0]         req_addr_i = 64'd0;
    logic                req_write_i = 1'b0;
    logic [IdWidth-1:0]  req_id_i = '0;
    logic [7:0]          req_len_i = 8'd0;
    logic                mst_valid_o;
    logic                mst_ready_i = 1'b0;
    logic [63:0]         mst_addr_o;
    logic                mst_write_o;
    logic [IdWidth-1:0]  mst_id_o;
    logic [7:0]          mst_len_o;
    logic [NbPeriph-1:0] mst_sel_o;
    logic [3:0]          mst_idx_o;
    logic                err_valid_o;
    logic                err_ready_i = 1'b0;
    logic [IdWidth-1:0]  err_id_o;
    logic [1:0]          err_resp_o;
    logic                err_last_o;
    logic                err_write_o;
    logic [CntWidth-1:0] decerr_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    soc_addr_decoder #(.NbPeriph(NbPeriph), .IdWidth(IdWidth), .CntWidth(CntWidth)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_write_i(req_write_i), .req_id_i(req_id_i), .req_len_i(req_len_i),
        .mst_valid_o(mst_valid_o), .mst_ready_i(mst_ready_i), .mst_addr_o(mst_addr_o),
        .mst_write_o(mst_write_o), .mst_id_o(mst_id_o), .mst_len_o(mst_len_o),
        .mst_sel_o(mst_sel_o), .mst_idx_o(mst_idx_o),
        .err_valid_o(err_valid_o), .err_ready_i(err_ready_i), .err_id_o(err_id_o),
        .err_resp_o(err_resp_o), .err_last_o(err_last_o), .err_write_o(err_write_o),
        .decerr_cnt_o(decerr_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference decode: first region (lowest index) whose [base, base+len) holds the address.
    function automatic int model_target(input logic [63:0] a);
        for (int i = 0; i < NbPeriph; i++) begin
            if (a >= MAP_BASE[i] && a < MAP_BASE[i] + MAP_LEN[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_idle(input string tag);
        #1;
        n_cmp++;
        if (mst_valid_o !== 1'b0 || mst_sel_o !== '0 || mst_idx_o !== 4'd0 || err_valid_o !== 1'b0 ||
            err_resp_o !== 2'b00 || err_last_o !== 1'b0 || err_id_o !== '0 || req_ready_o !== 1'b1 ||
            decerr_cnt_o !== CntWidth'(exp_cnt)) begin
            n_bad++;
            $display("FAIL idle_%s: mst_valid=%b sel=%h idx=%0d err_valid=%b resp=%b last=%b rdy=%b cnt=%0d, expected 0/0/0/0/0/0 rdy=1 cnt=%0d",
                     tag, mst_valid_o, mst_sel_o, mst_idx_o, err_valid_o, err_resp_o, err_last_o, req_ready_o, decerr_cnt_o, exp_cnt);
        end
    endtask

    task automatic send_mapped(input logic [63:0] a, input logic w, input logic [IdWidth-1:0] id,
                               input logic [7:0] len, input int tgt, input int hold);
        logic [NbPeriph-1:0] exp_sel;
        exp_sel = '0;
        exp_sel[tgt] = 1'b1;
        req_valid_i = 1'b1; req_addr_i = a; req_write_i = w; req_id_i = id; req_len_i = len;
        mst_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_addr_i = a + 64'h40;
        for (int c = 0; c <= hold; c++) begin
            req_valid_i = (c < hold);
            mst_ready_i = (c == hold);
            #1;
            n_cmp++;
            if (mst_valid_o !== 1'b1 || mst_idx_o !== tgt[3:0] || mst_sel_o !== exp_sel || mst_addr_o !== a ||
                mst_id_o !== id || mst_len_o !== len || mst_write_o !== w || req_ready_o !== (c == hold) ||
                err_valid_o !== 1'b0) begin
                n_bad++;
                $display("FAIL fwd %h cyc%0d: valid=%b idx=%0d sel=%h addr=%h id=%0d len=%0d wr=%b rdy=%b err_valid=%b, expected idx=%0d sel=%h id=%0d len=%0d wr=%b rdy=%b",
                         a, c, mst_valid_o, mst_idx_o, mst_sel_o, mst_addr_o, mst_id_o, mst_len_o, mst_write_o,
                         req_ready_o, err_valid_o, tgt, exp_sel, id, len, w, (c == hold));
            end
            @(negedge clk);
        end
        req_valid_i = 1'b0;
        mst_ready_i = 1'b0;
        check_idle("after_fwd");
    endtask

    task automatic send_err(input logic [63:0] a, input logic w, input logic [IdWidth-1:0] id,
                            input logic [7:0] len, input int stall_max);
        int nbeats;
        int stall;
        req_valid_i = 1'b1; req_addr_i = a; req_write_i = w; req_id_i = id; req_len_i = len;
        err_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (exp_cnt < (1 << CntWidth) - 1) exp_cnt++;
        // A request held valid during ERR must not be accepted.
        req_addr_i = 64'hFFFF_0000_0000_0000;
        req_write_i = ~w;
        nbeats = w ? 1 : int'(len) + 1;
        for (int b = 0; b < nbeats; b++) begin
            stall = $urandom_range(stall_max, 0);
            for (int c = 0; c <= stall; c++) begin
                err_ready_i = (c == stall);
                #1;
                n_cmp++;
                if (err_valid_o !== 1'b1 || err_resp_o !== 2'b11 || err_id_o !== id || err_write_o !== w ||
                    err_last_o !== (b == nbeats - 1) || req_ready_o !== 1'b0 || mst_valid_o !== 1'b0 ||
                    decerr_cnt_o !== CntWidth'(exp_cnt)) begin
                    n_bad++;
                    $display("FAIL err %h beat%0d/%0d: valid=%b resp=%b id=%0d wr=%b last=%b rdy=%b mst_valid=%b cnt=%0d, expected resp=11 id=%0d wr=%b last=%b rdy=0 cnt=%0d",
                             a, b + 1, nbeats, err_valid_o, err_resp_o, err_id_o, err_write_o, err_last_o, req_ready_o,
                             mst_valid_o, decerr_cnt_o, id, w, (b == nbeats - 1), exp_cnt);
                end
                @(negedge clk);
            end
        end
        req_valid_i = 1'b0;
        err_ready_i = 1'b0;
        check_idle("after_err");
    endtask

    task automatic run_req(input logic [63:0] a, input logic w, input logic [IdWidth-1:0] id,
                           input logic [7:0] len, input int tgt);
        if (tgt >= 0) send_mapped(a, w, id, len, tgt, $urandom_range(2, 0));
        else          send_err(a, w, id, len, 2);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("in_reset");
        rst_ni = 1'b1;
        @(negedge clk);
        check_idle("post_reset");
    endtask

    task automatic test_uart_read();
        send_mapped(64'h1000_0010, 1'b0, 5'd3, 8'd0, 6, 0);
    endtask

    task automatic test_boundaries();
        logic [63:0] addrs [6];
        int          tgts [6];
        addrs = '{64'h1000_0FFF, 64'h1000_1000, 64'hBFFF_FFFF, 64'hC000_0000, 64'h53FF_FFFE, 64'h53FF_FFFF};
        tgts  = '{6, -1, 1, -1, 0, -1};
        foreach (addrs[i]) run_req(addrs[i], 1'($urandom), 5'(i), 8'($urandom_range(3, 0)), tgts[i]);
        // Edges of every region, via the model.
        for (int k = 0; k < NbPeriph; k++) begin
            logic [63:0] pts [4];
            pts = '{MAP_BASE[k], MAP_BASE[k] + MAP_LEN[k] - 64'd1, MAP_BASE[k] + MAP_LEN[k], MAP_BASE[k] - 64'd1};
            foreach (pts[j]) run_req(pts[j], 1'b0, 5'(k), 8'd1, model_target(pts[j]));
        end
        run_req(64'h0000_0001_1000_0000, 1'b0, 5'd9, 8'd0, -1);
    endtask

    task automatic test_read_err();
        send_err(64'h6000_0000, 1'b0, 5'd5, 8'd3, 0);
    endtask

    task automatic test_write_err();
        send_err(64'h7000_0000, 1'b1, 5'd12, 8'd7, 0);
        send_err(64'h7000_0100, 1'b1, 5'd13, 8'd2, 3);
    endtask

    task automatic test_back_to_back();
        logic [63:0] a [3];
        a = '{64'h1_0000, 64'h1_0008, 64'h1_0010};
        req_valid_i = 1'b1; req_write_i = 1'b0; req_len_i = 8'd0;
        req_addr_i = a[0]; req_id_i = 5'd1; mst_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 1; i < 3; i++) begin
            req_addr_i = a[i]; req_id_i = 5'(i + 1);
            mst_ready_i = (i == 1);
            for (int s = 0; s < ((i == 1) ? 1 : 4); s++) begin
                mst_ready_i = (i == 1) || (s == 3);
                #1;
                n_cmp++;
                if (mst_valid_o !== 1'b1 || mst_addr_o !== a[i-1] || mst_id_o !== 5'(i) || mst_idx_o !== 4'd9 ||
                    mst_sel_o !== 11'h200 || req_ready_o !== mst_ready_i) begin
                    n_bad++;
                    $display("FAIL b2b req%0d cyc%0d: valid=%b addr=%h id=%0d idx=%0d sel=%h rdy=%b, expected addr=%h id=%0d idx=9 sel=200 rdy=%b",
                             i, s, mst_valid_o, mst_addr_o, mst_id_o, mst_idx_o, mst_sel_o, req_ready_o, a[i-1], i, mst_ready_i);
                end
                @(negedge clk);
            end
        end
        // Retire the last ROM read while an unmapped read enters directly into ERR.
        req_addr_i = 64'h6000_0000; req_id_i = 5'd7; mst_ready_i = 1'b1;
        #1;
        n_cmp++;
        if (mst_addr_o !== a[2] || mst_id_o !== 5'd3 || req_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b last: addr=%h id=%0d rdy=%b, expected addr=%h id=3 rdy=1", mst_addr_o, mst_id_o, req_ready_o, a[2]);
        end
        @(negedge clk);
        exp_cnt++;
        req_valid_i = 1'b0; mst_ready_i = 1'b0; err_ready_i = 1'b1;
        #1;
        n_cmp++;
        if (mst_valid_o !== 1'b0 || err_valid_o !== 1'b1 || err_last_o !== 1'b1 || err_id_o !== 5'd7 ||
            decerr_cnt_o !== CntWidth'(exp_cnt)) begin
            n_bad++;
            $display("FAIL b2b to_err: mst_valid=%b err_valid=%b last=%b id=%0d cnt=%0d, expected 0/1/1 id=7 cnt=%0d",
                     mst_valid_o, err_valid_o, err_last_o, err_id_o, decerr_cnt_o, exp_cnt);
        end
        @(negedge clk);
        err_ready_i = 1'b0;
        check_idle("b2b_end");
    endtask

    task automatic test_reset_mid();
        req_valid_i = 1'b1; req_addr_i = 64'h6000_0000; req_write_i = 1'b0; req_id_i = 5'd5; req_len_i = 8'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0; err_ready_i = 1'b1;
        @(negedge clk);
        err_ready_i = 1'b0;
        #1;
        n_cmp++;
        if (err_valid_o !== 1'b1 || err_last_o !== 1'b0 || err_id_o !== 5'd5) begin
            n_bad++;
            $display("FAIL rst_mid beat2: valid=%b last=%b id=%0d, expected 1/0/5", err_valid_o, err_last_o, err_id_o);
        end
        rst_ni = 1'b0;
        @(negedge clk);
        exp_cnt = 0;
        check_idle("rst_mid");
        rst_ni = 1'b1;
        @(negedge clk);
        send_mapped(64'h4000_0004, 1'b1, 5'd17, 8'd2, 2, 1);
        send_err(64'h6000_0000, 1'b0, 5'd6, 8'd2, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            logic [63:0] a;
            int k;
            k = $urandom_range(NbPeriph - 1, 0);
            case ($urandom_range(3, 0))
                0:       a = {32'($urandom), 32'($urandom)};
                1:       a = MAP_BASE[k] + 64'($urandom % 32'(MAP_LEN[k] + 64'd64)) - 64'd32;
                2:       a = MAP_BASE[k] + MAP_LEN[k] - 64'd1 + 64'($urandom_range(1, 0));
                default: a = {32'd0, 32'($urandom)};
            endcase
            // Ready inputs must be ignored while their valids are low.
            mst_ready_i = 1'($urandom); err_ready_i = 1'($urandom);
            @(negedge clk);
            mst_ready_i = 1'b0; err_ready_i = 1'b0;
            check_idle("rand_gap");
            run_req(a, 1'($urandom), 5'($urandom), 8'($urandom_range(5, 0)), model_target(a));
        end
    endtask

    initial begin
        test_reset();
        test_uart_read();
        test_read_err();
        test_boundaries();
        test_write_err();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
